serial_addsub: RTL

Parametrised bit-serial adder/subtractor. It is the sequential successor to the board-level 5-bit combinational adder/subtractor.
- Operands are captured on a start pulse and processed LSB-first, one bit per clock, through a single full-adder slice.
- The registered result comes back with a done pulse.
- Supports add/sub and signed/unsigned modes, with a WIDTH+1-bit result and an overflow flag. Intended to sit between SW/KEY inputs and LEDR/HEX outputs in the FPGA top.

---
 rtl/serial_addsub.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. Operands are captured on a start request and
// pushed LSB-first through a single full-adder slice, one bit per clock. After
// WIDTH bits the WIDTH+1-bit result and the overflow flag are registered and a
// one-cycle done pulse is raised. The FSM accepts a new request in IDLE and in
// DONE, so operations can run back to back with one op per WIDTH+1 cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   start        request, sampled only in IDLE or DONE
//   sub          0 = a+b, 1 = a-b (captured on start)
//   signed_mode  0 = unsigned, 1 = two's complement (captured on start)
//   a, b         WIDTH-bit operands (captured on start)
//   busy         high while the serial datapath is running
//   done         one-cycle pulse, result/overflow valid
//   result       WIDTH+1-bit registered result, held until the next done
//   overflow     registered overflow flag, updated with result
//
// WIDTH is legal from 2 to 32.
// -----------------------------------------------------------------------------
module serial_addsub #(
   parameter  int WIDTH = 5,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;         // operand A, shifted right each RUN cycle
   logic [WIDTH-1:0]   b_q, b_d;         // operand B', already inverted for sub
   logic               sub_q, sub_d;
   logic               signed_q, signed_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;     // sum bits enter at the top, LSB ends at bit 0
   logic [WIDTH:0]     result_q, result_d;
   logic               overflow_q, overflow_d;

   // Full-adder slice and end-of-operation flags
   logic a_bit, b_bit, sum_bit, carry_out, last_bit, msb_bit, ovf_bit, capture;

   assign a_bit     = a_q[0];
   assign b_bit     = b_q[0];
   assign sum_bit   = a_bit ^ b_bit ^ carry_q;
   assign carry_out = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
   assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

   // On the last bit, carry_q is the carry into the MSB and a_bit/b_bit are
   // the operand MSBs. Signed: the exact sign is the MSB sum with the final
   // carry, and overflow is carry-in XOR carry-out of the MSB. Unsigned: the
   // top bit is the carry for add and the borrow (inverted carry) for sub.
   assign msb_bit = signed_q ? (a_bit ^ b_bit ^ carry_out)
                             : (sub_q ? ~carry_out : carry_out);
   assign ovf_bit = signed_q ? (carry_q ^ carry_out)
                             : (sub_q ? ~carry_out : carry_out);

   // Requests are only accepted when the datapath is free.
   assign capture = start && (state_q == S_IDLE || state_q == S_DONE);

   // NOTE: every *_d gets its hold value first so no path through this block
   // leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sub_d      = sub_q;
      signed_d   = signed_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      sum_d      = sum_q;
      result_d   = result_q;
      overflow_d = overflow_q;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
            carry_d = carry_out;
            if (last_bit) begin
               state_d    = S_DONE;
               cnt_d      = '0;
               result_d   = {msb_bit, sum_bit, sum_q[WIDTH-1:1]};
               overflow_d = ovf_bit;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = start ? S_RUN : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Subtraction is a + ~b + 1: invert B here and feed the +1 as carry-in.
      if (capture) begin
         a_d      = a;
         b_d      = sub ? ~b : b;
         sub_d    = sub;
         signed_d = signed_mode;
         carry_d  = sub;
         cnt_d    = '0;
         sum_d    = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         signed_q   <= 1'b0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         sum_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sub_q      <= sub_d;
         signed_q   <= signed_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign result   = result_q;
   assign overflow = overflow_q;

endmodule
